// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the seven-segment loopback capture.
//   - bit positions of segments a..g and of the two digit selects in the display word
//   - active-high glyph table for hex digits 0..F
//   - glyph_decode(): 7-bit active-high pattern -> {valid, nibble}
package seg_pkg;

   localparam int unsigned SegA    = 0;
   localparam int unsigned SegB    = 1;
   localparam int unsigned SegC    = 2;
   localparam int unsigned SegD    = 3;
   localparam int unsigned SegE    = 4;
   localparam int unsigned SegF    = 5;
   localparam int unsigned SegG    = 6;
   localparam int unsigned SelLow  = 7;
   localparam int unsigned SelHigh = 8;

   // Active-high glyphs, bit0 = segment a. Entry i is the glyph for hex value i.
   localparam logic [15:0][6:0] GlyphTab = {
      7'h71,  // F  aefg
      7'h79,  // E  adefg
      7'h5E,  // d  bcdeg
      7'h39,  // C  adef
      7'h7C,  // b  cdefg
      7'h77,  // A  abcefg
      7'h6F,  // 9  abcdfg
      7'h7F,  // 8  abcdefg
      7'h07,  // 7  abc
      7'h7D,  // 6  acdefg
      7'h6D,  // 5  acdfg
      7'h66,  // 4  bcfg
      7'h4F,  // 3  abcdg
      7'h5B,  // 2  abdeg
      7'h06,  // 1  bc
      7'h3F   // 0  abcdef
   };

   // Returns {valid, nibble}; unknown patterns (including blank) give 5'b0.
   function automatic logic [4:0] glyph_decode(input logic [6:0] seg);
      logic [4:0] res;
      res = 5'b0;
      for (int i = 0; i < 16; i++) begin
         if (seg == GlyphTab[i]) res = {1'b1, 4'(i)};
      end
      return res;
   endfunction

endpackage

// File: rtl/seg_digit_track.sv
// seg_digit_track: stability tracker for one digit of the multiplexed display.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : current sample belongs to this digit's phase
//   pat        : segment pattern of the current sample (raw polarity)
//   com        : committed pattern (raw polarity)
//   seen       : at least one commit since reset
//   upd        : one-cycle pulse after a commit that changed com
module seg_digit_track
   import seg_pkg::*;
#(
   parameter int unsigned STABLE_CNT = 4,
   parameter logic [6:0]  BLANK      = 7'h7F
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [6:0] pat,
   output logic [6:0] com,
   output logic       seen,
   output logic       upd
);

   localparam logic [3:0] CntMax    = 4'(STABLE_CNT);
   localparam logic [3:0] CntCommit = 4'(STABLE_CNT - 1);

   logic [6:0] cand_q, cand_d;
   logic [3:0] cnt_q, cnt_d;
   logic [6:0] com_q, com_d;
   logic       seen_q, seen_d;
   logic       upd_q, upd_d;

   always_comb begin
      cand_d = cand_q;
      cnt_d  = cnt_q;
      com_d  = com_q;
      seen_d = seen_q;
      upd_d  = 1'b0;
      // Samples of the other phase or idle leave the run untouched.
      if (en) begin
         if (pat == cand_q) begin
            if (cnt_q != CntMax) cnt_d = cnt_q + 4'd1;
            // Commit only on the transition into saturation, so a held pattern commits once.
            if (cnt_q == CntCommit) begin
               com_d  = cand_q;
               seen_d = 1'b1;
               upd_d  = (cand_q != com_q);
            end
         end else begin
            cand_d = pat;
            cnt_d  = 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cand_q <= BLANK;
         cnt_q  <= 4'd0;
         com_q  <= BLANK;
         seen_q <= 1'b0;
         upd_q  <= 1'b0;
      end else begin
         cand_q <= cand_d;
         cnt_q  <= cnt_d;
         com_q  <= com_d;
         seen_q <= seen_d;
         upd_q  <= upd_d;
      end
   end

   assign com  = com_q;
   assign seen = seen_q;
   assign upd  = upd_q;

endmodule

// File: rtl/seg_capture.sv
// seg_capture: loopback capture of the time-multiplexed two-digit seven-segment bus.
//   clk, rst_n               : clock, synchronous active-low reset
//   seven_seg[11:0]          : [6:0] segments a..g, [7] low select (0 = on),
//                              [8] high select (0 = on), [11:9] ignored
//   low_nibble, high_nibble  : decoded committed value per digit
//   low_valid, high_valid    : committed pattern is a legal hex glyph
//   low_seen, high_seen      : at least one commit since reset
//   update                   : pulse when either committed pattern changes
//   err                      : high while the sample register holds a both-selected word
module seg_capture
   import seg_pkg::*;
#(
   parameter int unsigned STABLE_CNT     = 4,
   parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] seven_seg,
   output logic [3:0]  low_nibble,
   output logic [3:0]  high_nibble,
   output logic        low_valid,
   output logic        high_valid,
   output logic        low_seen,
   output logic        high_seen,
   output logic        update,
   output logic        err
);

   localparam logic [6:0] Blank = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

   logic [11:0] s_q;
   logic        low_ph, high_ph;
   logic [6:0]  low_com, high_com;
   logic        low_upd, high_upd;
   logic [4:0]  low_dec, high_dec;
   logic        unused_bits;

   always_ff @(posedge clk) begin
      if (!rst_n) s_q <= 12'hFFF;
      else        s_q <= seven_seg;
   end

   assign unused_bits = ^s_q[11:9];

   always_comb begin
      low_ph  = !s_q[SelLow] && s_q[SelHigh];
      high_ph = s_q[SelLow] && !s_q[SelHigh];
      err     = !s_q[SelLow] && !s_q[SelHigh];
   end

   seg_digit_track #(
      .STABLE_CNT (STABLE_CNT),
      .BLANK      (Blank)
   ) u_low (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (low_ph),
      .pat   (s_q[6:0]),
      .com   (low_com),
      .seen  (low_seen),
      .upd   (low_upd)
   );

   seg_digit_track #(
      .STABLE_CNT (STABLE_CNT),
      .BLANK      (Blank)
   ) u_high (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (high_ph),
      .pat   (s_q[6:0]),
      .com   (high_com),
      .seen  (high_seen),
      .upd   (high_upd)
   );

   // Glyph table is active-high; flip the committed pattern first when the bus is active-low.
   always_comb begin
      low_dec  = glyph_decode(SEG_ACTIVE_LOW ? ~low_com : low_com);
      high_dec = glyph_decode(SEG_ACTIVE_LOW ? ~high_com : high_com);
   end

   assign low_nibble  = low_dec[3:0];
   assign low_valid   = low_dec[4];
   assign high_nibble = high_dec[3:0];
   assign high_valid  = high_dec[4];

   // Phases are exclusive, so the two pulses never coincide.
   assign update = low_upd | high_upd;

endmodule

// File: tb/tb_seg_capture.sv
// tb_seg_capture: directed table-driven bench for seg_capture (STABLE_CNT=4, active-low).
module tb_seg_capture;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] seven_seg;
   logic [3:0]  low_nibble, high_nibble;
   logic        low_valid, high_valid, low_seen, high_seen, update, err;

   int errors = 0;
   int checks = 0;
   int upd_cnt = 0;
   int err_cnt = 0;

   seg_capture #(
      .STABLE_CNT     (4),
      .SEG_ACTIVE_LOW (1'b1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seven_seg   (seven_seg),
      .low_nibble  (low_nibble),
      .high_nibble (high_nibble),
      .low_valid   (low_valid),
      .high_valid  (high_valid),
      .low_seen    (low_seen),
      .high_seen   (high_seen),
      .update      (update),
      .err         (err)
   );

   always #5 clk = ~clk;

   // Pulse counters, sampled mid-cycle.
   always @(negedge clk) begin
      if (update === 1'b1) upd_cnt++;
      if (err === 1'b1) err_cnt++;
   end

   typedef struct {
      logic [11:0] din;
      int          n;
      logic [3:0]  lo_nib;
      logic        lo_val;
      logic        lo_seen;
      logic [3:0]  hi_nib;
      logic        hi_val;
      logic        hi_seen;
      int          upd;
      int          errs;
   } vec_t;

   vec_t tbl[17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // n rising edges, then settle to just after the following falling edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic check_outs(input string tag, input logic [3:0] lo_nib, input logic lo_val,
                             input logic lo_seen, input logic [3:0] hi_nib,
                             input logic hi_val, input logic hi_seen);
      check({tag, " low_nibble"}, 32'(low_nibble), 32'(lo_nib));
      check({tag, " low_valid"}, 32'(low_valid), 32'(lo_val));
      check({tag, " low_seen"}, 32'(low_seen), 32'(lo_seen));
      check({tag, " high_nibble"}, 32'(high_nibble), 32'(hi_nib));
      check({tag, " high_valid"}, 32'(high_valid), 32'(hi_val));
      check({tag, " high_seen"}, 32'(high_seen), 32'(hi_seen));
   endtask

   initial begin
      int u0, e0;

      //        din     n   lnib  lv    ls    hnib  hv    hs   upd err
      tbl[0]  = '{12'h179, 5, 4'd1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1, 0};  // low '1'
      tbl[1]  = '{12'h179, 3, 4'd1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 0, 0};  // held: quiet
      tbl[2]  = '{12'h140, 1, 4'd1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 0, 0};  // glitch
      tbl[3]  = '{12'h179, 5, 4'd1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 0, 0};  // recommit same
      tbl[4]  = '{12'h140, 5, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1, 0};  // low '0'
      tbl[5]  = '{12'h0B0, 5, 4'd0, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 1, 0};  // high '3'
      tbl[6]  = '{12'h179, 32, 4'd1, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 1, 0}; // alternating
      tbl[7]  = '{12'h0B0, 32, 4'd1, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 0, 0};
      tbl[8]  = '{12'h179, 32, 4'd1, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 0, 0};
      tbl[9]  = '{12'h0B0, 32, 4'd1, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 0, 0};
      tbl[10] = '{12'h079, 1, 4'd1, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 0, 1};  // conflict
      tbl[11] = '{12'h1FF, 3, 4'd1, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 0, 0};  // idle
      tbl[12] = '{12'h140, 3, 4'd1, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 0, 0};  // run to cnt 2
      tbl[13] = '{12'h079, 1, 4'd1, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 0, 1};  // cnt 3, conflict in s
      tbl[14] = '{12'h1FF, 1, 4'd1, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 0, 0};  // conflict ignored
      tbl[15] = '{12'h140, 2, 4'd0, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 1, 0};  // run resumes, commits
      tbl[16] = '{12'h17F, 5, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1, 0};  // blank: illegal

      // Reset with random bus activity.
      rst_n = 1'b0;
      seven_seg = 12'($urandom);
      for (int i = 0; i < 3; i++) begin
         seven_seg = 12'($urandom);
         tick(1);
         check_outs($sformatf("reset[%0d]", i), 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
         check($sformatf("reset[%0d] update", i), 32'(update), 32'd0);
         check($sformatf("reset[%0d] err", i), 32'(err), 32'd0);
      end

      rst_n = 1'b1;
      seven_seg = 12'h1FF;

      for (int i = 0; i < 17; i++) begin
         u0 = upd_cnt;
         e0 = err_cnt;
         seven_seg = tbl[i].din;
         tick(tbl[i].n);
         check_outs($sformatf("vec%0d", i), tbl[i].lo_nib, tbl[i].lo_val, tbl[i].lo_seen,
                    tbl[i].hi_nib, tbl[i].hi_val, tbl[i].hi_seen);
         check($sformatf("vec%0d update pulses", i), 32'(upd_cnt - u0), 32'(tbl[i].upd));
         check($sformatf("vec%0d err pulses", i), 32'(err_cnt - e0), 32'(tbl[i].errs));
      end

      // Reset in the middle of a 2-sample run: the run must be discarded.
      u0 = upd_cnt;
      seven_seg = 12'h179;
      tick(3);
      check("midrun pre-reset low_valid", 32'(low_valid), 32'd0);
      check("midrun pre-reset update pulses", 32'(upd_cnt - u0), 32'd0);
      rst_n = 1'b0;
      tick(1);
      check_outs("midrun in-reset", 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      u0 = upd_cnt;
      tick(4);
      check("midrun early low_seen", 32'(low_seen), 32'd0);
      check("midrun early update pulses", 32'(upd_cnt - u0), 32'd0);
      tick(1);
      check_outs("midrun commit", 4'd1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
      check("midrun commit update pulses", 32'(upd_cnt - u0), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
